pipe_hazard_unit: RTL and testbench

- Parametrised hazard/forwarding controller for the pipelined MIPS core. Successor to the fixed EX/MEM/WB forwarding and load-use stall logic.
- Keeps its own scoreboard of in-flight destination registers from EX to the last forwarding stage, so it never reads the pipeline registers directly.
- Produces forwarding selects for the EX operands, ID/IF stall, an EX hold for a multi-cycle multiply/divide unit (MDU), and per-boundary flush strobes for taken branches and jumps.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_chk.sv | 25 ++
 rtl/hazard_scoreboard.sv | 51 +++++
 rtl/pipe_hazard_unit.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int RW_MAX = 16;

  localparam int FWD_ID  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  localparam int FLUSH_IFID  = 0;
  localparam int FLUSH_IDEX  = 1;
  localparam int FLUSH_SLOT0 = 2;

  typedef logic [RW_MAX-1:0] gpr_t;

  typedef struct packed {
    logic valid;
    logic regw;
    logic load;
    gpr_t dest;
    gpr_t rs;
    gpr_t rt;
    logic use_rs;
    logic use_rt;
  } sb_slot_t;

  localparam sb_slot_t SB_BUBBLE = '0;

  // Register 0 is hardwired, so it can never create a dependency.
  function automatic logic reg_match(input gpr_t src, input gpr_t dst);
    return (src != '0) && (src == dst);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/hazard_chk.sv
// Simulation checker: a load result must never be forwarded from a stage
// earlier than the one where its data becomes available.
module hazard_chk #(
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2,
  parameter int FSEL_W     = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic [FSEL_W-1:0] fwd_a_i,
  input logic [FSEL_W-1:0] fwd_b_i,
  input logic [DEPTH:0]    load_vec_i
);

  function automatic logic early_load_fwd(input logic [FSEL_W-1:0] sel,
                                          input logic [DEPTH:0] lv);
    return (sel != '0) && (int'(sel) < LOAD_READY) && lv[sel];
  endfunction

  a_fwd_a_load: assert property (@(posedge clk_i) disable iff (rst_i)
                                 !early_load_fwd(fwd_a_i, load_vec_i));
  a_fwd_b_load: assert property (@(posedge clk_i) disable iff (rst_i)
                                 !early_load_fwd(fwd_b_i, load_vec_i));

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight instructions from EX (slot 0) to the last
// result-holding stage, with bubble insertion for stall, EX hold and branch flush.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int BR_STAGE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  sb_slot_t             id_slot_i,
  input  logic                 stall_i,
  input  logic                 ex_hold_i,
  input  logic                 br_taken_i,
  output sb_slot_t [DEPTH:0]   slots_o
);

  sb_slot_t [DEPTH:0] slots_q;
  sb_slot_t [DEPTH:0] slots_d;

  always_comb begin
    slots_d[0] = id_slot_i;
    for (int k = 1; k <= DEPTH; k++) begin
      slots_d[k] = slots_q[k-1];
    end
    if (br_taken_i) begin
      // Everything younger than the resolving branch is squashed.
      for (int k = 0; k <= BR_STAGE; k++) begin
        slots_d[k] = SB_BUBBLE;
      end
    end else if (ex_hold_i) begin
      slots_d[0] = slots_q[0];
      slots_d[1] = SB_BUBBLE;
    end else if (stall_i) begin
      slots_d[0] = SB_BUBBLE;
    end else begin
      slots_d[0] = id_slot_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q <= '0;
    end else begin
      slots_q <= slots_d;
    end
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: operand forwarding, load-use stall, MDU hold and
// branch/jump flush. Define HAZARD_PERF_EN to add saturating perf counters.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int RW         = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2,
  parameter int MDU_LAT    = 4,
  parameter int BR_STAGE   = 1,
  parameter int FSEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [RW-1:0]       id_rs_i,
  input  logic [RW-1:0]       id_rt_i,
  input  logic                id_use_rs_i,
  input  logic                id_use_rt_i,
  input  logic [RW-1:0]       id_dest_i,
  input  logic                id_regw_i,
  input  logic                id_load_i,
  input  logic                id_mdu_i,
  input  logic                id_jump_i,
  input  logic                br_taken_i,
  output logic                stall_o,
  output logic                ex_hold_o,
  output logic [BR_STAGE+1:0] flush_o,
  output logic [FSEL_W-1:0]   fwd_a_o,
  output logic [FSEL_W-1:0]   fwd_b_o,
  output logic                mdu_busy_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cyc_o,
  output logic [31:0]         perf_hold_cyc_o,
  output logic [31:0]         perf_flush_evt_o
`endif
);

  localparam int MDU_CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [MDU_CW-1:0] MDU_LOAD = MDU_CW'(MDU_LAT - 1);
  localparam logic BR_CLEARS_MDU = (BR_STAGE >= 1);

  sb_slot_t             id_slot_s;
  sb_slot_t [DEPTH:0]   slots_s;
  logic [DEPTH:0]       load_vec_s;
  logic                 load_use_s;
  logic                 mdu_busy_s;
  logic                 stall_s;
  logic                 ex_hold_s;
  logic [BR_STAGE+1:0]  flush_s;
  logic [FSEL_W-1:0]    fwd_a_s;
  logic [FSEL_W-1:0]    fwd_b_s;
  logic [MDU_CW-1:0]    cnt_q;
  logic [MDU_CW-1:0]    cnt_d;

  // Youngest producer wins: scan oldest to youngest so the smallest k is kept.
  function automatic logic [FSEL_W-1:0] fwd_sel(input gpr_t src, input logic use_src,
                                                input sb_slot_t [DEPTH:0] sl);
    logic [FSEL_W-1:0] sel;
    sel = FSEL_W'(FWD_ID);
    for (int k = DEPTH; k >= FWD_MEM; k--) begin
      sel = (sl[0].valid && use_src && sl[k].valid && sl[k].regw &&
             reg_match(src, sl[k].dest)) ? FSEL_W'(k) : sel;
    end
    return sel;
  endfunction

  function automatic logic load_hit(input gpr_t src, input logic use_src,
                                    input sb_slot_t [DEPTH:0] sl);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      hit = hit | ((j + 1 < LOAD_READY) && use_src && sl[j].valid && sl[j].load &&
                   sl[j].regw && reg_match(src, sl[j].dest));
    end
    return hit;
  endfunction

  // Pack the ID-stage instruction into a scoreboard slot.
  always_comb begin
    id_slot_s        = SB_BUBBLE;
    id_slot_s.valid  = id_valid_i;
    id_slot_s.regw   = id_regw_i;
    id_slot_s.load   = id_load_i;
    id_slot_s.dest   = gpr_t'(id_dest_i);
    id_slot_s.rs     = gpr_t'(id_rs_i);
    id_slot_s.rt     = gpr_t'(id_rt_i);
    id_slot_s.use_rs = id_use_rs_i;
    id_slot_s.use_rt = id_use_rt_i;
  end

  hazard_scoreboard #(
    .DEPTH    (DEPTH),
    .BR_STAGE (BR_STAGE)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .id_slot_i  (id_slot_s),
    .stall_i    (stall_s),
    .ex_hold_i  (ex_hold_s),
    .br_taken_i (br_taken_i),
    .slots_o    (slots_s)
  );

  assign fwd_a_s    = fwd_sel(slots_s[0].rs, slots_s[0].use_rs, slots_s);
  assign fwd_b_s    = fwd_sel(slots_s[0].rt, slots_s[0].use_rt, slots_s);
  assign load_use_s = id_valid_i &
                      (load_hit(gpr_t'(id_rs_i), id_use_rs_i, slots_s) |
                       load_hit(gpr_t'(id_rt_i), id_use_rt_i, slots_s));
  assign mdu_busy_s = (cnt_q != '0);

  // Priority: branch flush > MDU hold > load-use stall > jump flush.
  always_comb begin
    stall_s   = 1'b0;
    ex_hold_s = 1'b0;
    flush_s   = '0;
    if (br_taken_i) begin
      flush_s = '1;
    end else if (mdu_busy_s) begin
      stall_s   = 1'b1;
      ex_hold_s = 1'b1;
    end else if (load_use_s) begin
      stall_s = 1'b1;
    end else if (id_jump_i) begin
      flush_s[FLUSH_IFID] = 1'b1;
    end else begin
      flush_s = '0;
    end
  end

  // MDU occupancy: loaded as the op enters EX, counts down the remaining hold cycles.
  always_comb begin
    if (br_taken_i && BR_CLEARS_MDU) begin
      cnt_d = '0;
    end else if (mdu_busy_s) begin
      cnt_d = cnt_q - MDU_CW'(1);
    end else if (id_valid_i && id_mdu_i && !stall_s && !br_taken_i) begin
      cnt_d = MDU_LOAD;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k <= DEPTH; k++) begin
      load_vec_s[k] = slots_s[k].valid & slots_s[k].regw & slots_s[k].load;
    end
  end

  hazard_chk #(
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .FSEL_W     (FSEL_W)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .fwd_a_i    (fwd_a_s),
    .fwd_b_i    (fwd_b_s),
    .load_vec_i (load_vec_s)
  );

  assign stall_o    = stall_s;
  assign ex_hold_o  = ex_hold_s;
  assign flush_o    = flush_s;
  assign fwd_a_o    = fwd_a_s;
  assign fwd_b_o    = fwd_b_s;
  assign mdu_busy_o = mdu_busy_s;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_hold_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q <= 32'd0;
      perf_hold_q  <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= sat_inc(perf_stall_q, stall_s);
      perf_hold_q  <= sat_inc(perf_hold_q, ex_hold_s);
      perf_flush_q <= sat_inc(perf_flush_q, |flush_s);
    end
  end

  assign perf_stall_cyc_o = perf_stall_q;
  assign perf_hold_cyc_o  = perf_hold_q;
  assign perf_flush_evt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed hazard scenarios followed by random
// instruction streams, all checked against an in-order pipeline queue model.
module tb_pipe_hazard_unit;

  localparam int RW         = 5;
  localparam int DEPTH      = 2;
  localparam int LOAD_READY = 2;
  localparam int MDU_LAT    = 4;
  localparam int BR_STAGE   = 1;
  localparam int FSEL_W     = $clog2(DEPTH + 1);
  localparam int FLW        = BR_STAGE + 2;

  typedef struct packed {
    logic          valid;
    logic          regw;
    logic          load;
    logic          mdu;
    logic          use_rs;
    logic          use_rt;
    logic [RW-1:0] dest;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
  } ins_t;

  localparam ins_t BUB = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic [RW-1:0]     id_rs = '0;
  logic [RW-1:0]     id_rt = '0;
  logic              id_use_rs = 1'b0;
  logic              id_use_rt = 1'b0;
  logic [RW-1:0]     id_dest = '0;
  logic              id_regw = 1'b0;
  logic              id_load = 1'b0;
  logic              id_mdu = 1'b0;
  logic              id_jump = 1'b0;
  logic              br_taken = 1'b0;
  logic              stall;
  logic              ex_hold;
  logic [FLW-1:0]    flush;
  logic [FSEL_W-1:0] fwd_a;
  logic [FSEL_W-1:0] fwd_b;
  logic              mdu_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]       perf_stall_cyc;
  logic [31:0]       perf_hold_cyc;
  logic [31:0]       perf_flush_evt;
`endif

  pipe_hazard_unit #(
    .RW(RW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .MDU_LAT(MDU_LAT), .BR_STAGE(BR_STAGE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dest_i(id_dest),
    .id_regw_i(id_regw), .id_load_i(id_load), .id_mdu_i(id_mdu), .id_jump_i(id_jump),
    .br_taken_i(br_taken), .stall_o(stall), .ex_hold_o(ex_hold), .flush_o(flush),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .mdu_busy_o(mdu_busy)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cyc_o(perf_stall_cyc), .perf_hold_cyc_o(perf_hold_cyc),
    .perf_flush_evt_o(perf_flush_evt)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  ins_t pipe[$];      // pipe[0] = EX, pipe[k] = k stages after EX
  int   mdu_left = 0;
  bit   exp_stall_r = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input bit regw, input bit ld, input bit mdu,
                              input logic [RW-1:0] dest, input logic [RW-1:0] rs,
                              input logic [RW-1:0] rt, input bit urs, input bit urt);
    ins_t i;
    i = '{valid: 1'b1, regw: regw, load: ld, mdu: mdu, use_rs: urs, use_rt: urt,
          dest: dest, rs: rs, rt: rt};
    return i;
  endfunction

  function automatic bit reads(input ins_t i, input logic [RW-1:0] r);
    return i.valid && (r != '0) && ((i.use_rs && i.rs == r) || (i.use_rt && i.rt == r));
  endfunction

  // Nearest older instruction writing the source register, 0 when none.
  function automatic int exp_fwd(input logic [RW-1:0] src, input bit use_src);
    if (!(pipe[0].valid && use_src && src != '0)) return 0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (pipe[k].valid && pipe[k].regw && pipe[k].dest == src) return k;
    end
    return 0;
  endfunction

  task automatic model_clear();
    pipe.delete();
    for (int k = 0; k <= DEPTH; k++) pipe.push_back(BUB);
    mdu_left = 0;
    exp_stall_r = 1'b0;
  endtask

  task automatic drive(input ins_t id, input bit jmp, input bit br);
    id_valid = id.valid; id_rs = id.rs; id_rt = id.rt;
    id_use_rs = id.use_rs; id_use_rt = id.use_rt; id_dest = id.dest;
    id_regw = id.regw; id_load = id.load; id_mdu = id.mdu;
    id_jump = jmp; br_taken = br;
  endtask

  task automatic cycle(input ins_t id, input bit jmp, input bit br);
    bit   busy, lu, e_stall, e_hold;
    int   e_flush;
    ins_t m;
    @(negedge clk);
    drive(id, jmp, br);
    #1;
    busy = (mdu_left > 0);
    lu = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if ((j + 1 < LOAD_READY) && pipe[j].valid && pipe[j].load && pipe[j].regw &&
          reads(id, pipe[j].dest)) lu = 1'b1;
    end
    e_stall = !br && (busy || lu);
    e_hold  = !br && busy;
    e_flush = br ? ((1 << FLW) - 1) : ((jmp && !busy && !lu) ? 1 : 0);
    check("stall", 32'(stall), 32'(e_stall));
    check("ex_hold", 32'(ex_hold), 32'(e_hold));
    check("flush", 32'(flush), e_flush);
    check("fwd_a", 32'(fwd_a), exp_fwd(pipe[0].rs, pipe[0].use_rs));
    check("fwd_b", 32'(fwd_b), exp_fwd(pipe[0].rt, pipe[0].use_rt));
    check("mdu_busy", 32'(mdu_busy), 32'(busy));
    if (br) begin
      pipe.push_front(id);
      void'(pipe.pop_back());
      for (int k = 0; k <= BR_STAGE; k++) pipe[k] = BUB;
      if (BR_STAGE >= 1) mdu_left = 0;
      else if (mdu_left > 0) mdu_left--;
    end else if (e_hold) begin
      m = pipe.pop_front();
      pipe.push_front(BUB);
      pipe.push_front(m);
      void'(pipe.pop_back());
      mdu_left--;
    end else if (e_stall) begin
      pipe.push_front(BUB);
      void'(pipe.pop_back());
    end else begin
      pipe.push_front(id);
      void'(pipe.pop_back());
      if (id.valid && id.mdu) mdu_left = MDU_LAT - 1;
    end
    exp_stall_r = e_stall;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(BUB, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ex_hold", 32'(ex_hold), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    check("rst_fwd_b", 32'(fwd_b), 32'd0);
    check("rst_mdu_busy", 32'(mdu_busy), 32'd0);
    model_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(BUB, 1'b0, 1'b0);
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    int   kind;
    kind = $urandom_range(0, 9);
    i = mk(kind != 0, kind inside {[1:3]}, kind == 0,
           RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
    i.valid = ($urandom_range(0, 7) != 0);
    return i;
  endfunction

  initial begin
    ins_t add2, cur;
    bit   jmp, br;
    model_clear();
    do_reset();

    // add $3,$1,$2 ; sub $4,$3,$5
    cycle(mk(1, 0, 0, 5'd3, 5'd1, 5'd2, 1, 1), 1'b0, 1'b0);
    cycle(mk(1, 0, 0, 5'd4, 5'd3, 5'd5, 1, 1), 1'b0, 1'b0);
    cycle(BUB, 1'b0, 1'b0);
    check("raw_fwd_a", 32'(fwd_a), 32'd1);
    check("raw_stall", 32'(stall), 32'd0);
    drain();

    // lw $3,0($0) ; add $4,$3,$3
    cycle(mk(1, 1, 0, 5'd3, 5'd0, 5'd0, 1, 0), 1'b0, 1'b0);
    cycle(mk(1, 0, 0, 5'd4, 5'd3, 5'd3, 1, 1), 1'b0, 1'b0);
    check("lu_stall", 32'(stall), 32'd1);
    cycle(mk(1, 0, 0, 5'd4, 5'd3, 5'd3, 1, 1), 1'b0, 1'b0);
    check("lu_one_bubble", 32'(stall), 32'd0);
    cycle(BUB, 1'b0, 1'b0);
    check("lu_fwd_a", 32'(fwd_a), 32'd2);
    check("lu_fwd_b", 32'(fwd_b), 32'd2);
    drain();

    // load to $0, then read $0
    cycle(mk(1, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0), 1'b0, 1'b0);
    cycle(mk(1, 0, 0, 5'd4, 5'd0, 5'd0, 1, 1), 1'b0, 1'b0);
    check("r0_stall", 32'(stall), 32'd0);
    cycle(BUB, 1'b0, 1'b0);
    check("r0_fwd_a", 32'(fwd_a), 32'd0);
    check("r0_fwd_b", 32'(fwd_b), 32'd0);
    drain();

    // mult then add: three held cycles
    add2 = mk(1, 0, 0, 5'd5, 5'd6, 5'd7, 1, 1);
    cycle(mk(0, 0, 1, 5'd0, 5'd1, 5'd2, 1, 1), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(add2, 1'b0, 1'b0);
      check("mdu_hold", 32'(ex_hold), 32'd1);
      check("mdu_stall", 32'(stall), 32'd1);
    end
    cycle(add2, 1'b0, 1'b0);
    check("mdu_busy_fall", 32'(mdu_busy), 32'd0);
    check("mdu_release", 32'(stall), 32'd0);
    drain();

    // branch resolving in MEM while a load-use stall is pending
    cycle(mk(0, 0, 0, 5'd0, 5'd1, 5'd2, 1, 1), 1'b0, 1'b0);
    cycle(mk(1, 1, 0, 5'd3, 5'd0, 5'd0, 1, 0), 1'b0, 1'b0);
    cycle(mk(1, 0, 0, 5'd4, 5'd3, 5'd3, 1, 1), 1'b0, 1'b1);
    check("br_flush", 32'(flush), 32'd7);
    check("br_stall", 32'(stall), 32'd0);
    cycle(mk(1, 0, 0, 5'd6, 5'd3, 5'd0, 1, 0), 1'b0, 1'b0);
    check("br_squashed_load", 32'(stall), 32'd0);
    cycle(BUB, 1'b0, 1'b0);
    check("br_squashed_fwd", 32'(fwd_a), 32'd0);

    // jump
    cycle(BUB, 1'b1, 1'b0);
    check("jump_flush", 32'(flush), 32'd1);
    cycle(BUB, 1'b0, 1'b0);
    check("jump_flush_end", 32'(flush), 32'd0);

    // reset in the middle of an MDU hold
    cycle(mk(0, 0, 1, 5'd0, 5'd1, 5'd2, 1, 1), 1'b0, 1'b0);
    cycle(add2, 1'b0, 1'b0);
    check("mdu_busy_pre_rst", 32'(mdu_busy), 32'd1);
    do_reset();

    // random instruction stream; stalled instructions are re-presented
    cur = BUB;
    jmp = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!exp_stall_r) begin
        cur = rand_ins();
        jmp = ($urandom_range(0, 15) == 0);
      end
      br = pipe[BR_STAGE].valid && ($urandom_range(0, 9) == 0);
      cycle(cur, jmp, br);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
